// File: rtl/univ_counter_pkg.sv
// Shared constants for the universal up/down counter: direction and mode
// encodings plus the default parameter values used by the counter and its
// optional prescaler.
package univ_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam int DEFAULT_N       = 8;
   localparam int DEFAULT_PRE_DIV = 4;

endpackage

// File: rtl/count_prescaler.sv
// Modulo-PRE_DIV prescaler for univ_counter. It advances while enable is
// high, is forced back to 0 by clear, and flags the cycle in which it sits
// on its last value with enable high so the counter can take one step.
module count_prescaler
   import univ_counter_pkg::*;
#(
   parameter int PRE_DIV = DEFAULT_PRE_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int            CW   = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRE_DIV - 1);
   localparam logic [CW-1:0] ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;

   // Next prescale value: clear wins, otherwise advance modulo PRE_DIV while enabled.
   always_comb begin
      cnt_next_s = cnt_r;
      if (clear) begin
         cnt_next_s = ZERO;
      end else if (enable) begin
         if (cnt_r == LAST) begin
            cnt_next_s = ZERO;
         end else begin
            cnt_next_s = cnt_r + ONE;
         end
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Prescale state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= ZERO;
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

   assign terminal = enable & (cnt_r == LAST);

endmodule

// File: rtl/univ_counter.sv
// Universal N-bit counter with runtime terminal value `limit`: synchronous
// clear, parallel load, up/down stepping with wrap or saturate behaviour,
// and combinational max/min/wrap indications.
// Optional feature: define UNIV_COUNTER_PRESCALE_EN to insert a PRE_DIV
// prescaler so that a step only happens once every PRE_DIV enabled cycles.
module univ_counter
   import univ_counter_pkg::*;
#(
   parameter int N       = DEFAULT_N,
   parameter int PRE_DIV = DEFAULT_PRE_DIV
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         syn_clr,
   input  logic         load,
   input  logic         en,
   input  logic         up,
   input  logic         sat,
   input  logic [N-1:0] d,
   input  logic [N-1:0] limit,
   output logic [N-1:0] q,
   output logic         max_tick,
   output logic         min_tick,
   output logic         wrap_tick
);

   localparam logic [N-1:0] ZERO = {N{1'b0}};
   localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] q_r;
   logic [N-1:0] q_next_s;
   logic         step_s;
   logic         at_top_s;
   logic         at_zero_s;
   logic         wrap_s;

`ifdef UNIV_COUNTER_PRESCALE_EN
   logic pre_term_s;
   logic pre_clear_s;

   // Load and clear restart the prescale phase so a fresh value gets a full period.
   assign pre_clear_s = syn_clr | load;

   count_prescaler #(
      .PRE_DIV (PRE_DIV)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .clear    (pre_clear_s),
      .enable   (en),
      .terminal (pre_term_s)
   );

   assign step_s = en & pre_term_s;
`else
   assign step_s = en;
`endif

   // q above limit (after a load of d > limit) is treated like q at limit.
   assign at_top_s  = (q_r >= limit);
   assign at_zero_s = (q_r == ZERO);

   // Wrap only when a real step happens in wrap mode at a bound; clear/load/reset pre-empt the step.
   always_comb begin
      wrap_s = 1'b0;
      if (reset | syn_clr | load) begin
         wrap_s = 1'b0;
      end else if (step_s && (sat == MODE_WRAP)) begin
         wrap_s = ((up == DIR_UP) && at_top_s) || ((up == DIR_DOWN) && at_zero_s);
      end else begin
         wrap_s = 1'b0;
      end
   end

   // Next count with priority clear > load > step > hold.
   always_comb begin
      q_next_s = q_r;
      if (syn_clr) begin
         q_next_s = ZERO;
      end else if (load) begin
         q_next_s = d;
      end else if (step_s) begin
         if (up == DIR_UP) begin
            if (!at_top_s) begin
               q_next_s = q_r + ONE;
            end else if (sat == MODE_SAT) begin
               q_next_s = limit;
            end else begin
               q_next_s = ZERO;
            end
         end else begin
            if (!at_zero_s) begin
               q_next_s = q_r - ONE;
            end else if (sat == MODE_SAT) begin
               q_next_s = ZERO;
            end else begin
               q_next_s = limit;
            end
         end
      end else begin
         q_next_s = q_r;
      end
   end

   // Count register; synchronous reset overrides every other control.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r <= ZERO;
      end else begin
         q_r <= q_next_s;
      end
   end

   assign q         = q_r;
   assign max_tick  = (q_r == limit);
   assign min_tick  = at_zero_s;
   assign wrap_tick = wrap_s;

endmodule

// File: tb/tb_univ_counter.sv
// Self-checking bench for univ_counter (N=4, PRE_DIV=4). A behavioural model
// built from plain integer arithmetic tracks the expected count; directed
// scenarios add literal expectations, then a randomized run compares every
// output every cycle. Works with or without UNIV_COUNTER_PRESCALE_EN.
module tb_univ_counter;

   localparam int N       = 4;
   localparam int PRE_DIV = 4;

   logic         clk = 1'b0;
   logic         reset, syn_clr, load, en, up, sat;
   logic [N-1:0] d, limit;
   logic [N-1:0] q;
   logic         max_tick, min_tick, wrap_tick;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int mq   = 0;
   int mpre = 0;

   always #5 clk = ~clk;

   univ_counter #(.N(N), .PRE_DIV(PRE_DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .syn_clr   (syn_clr),
      .load      (load),
      .en        (en),
      .up        (up),
      .sat       (sat),
      .d         (d),
      .limit     (limit),
      .q         (q),
      .max_tick  (max_tick),
      .min_tick  (min_tick),
      .wrap_tick (wrap_tick)
   );

   function automatic bit m_step();
`ifdef UNIV_COUNTER_PRESCALE_EN
      return en && (mpre == PRE_DIV - 1);
`else
      return en;
`endif
   endfunction

   function automatic bit m_wrap();
      return !reset && !syn_clr && !load && m_step() && !sat &&
             ((up && mq >= int'(limit)) || (!up && mq == 0));
   endfunction

   function automatic void m_clock();
      bit stp;
      stp = m_step();
      if (reset) begin
         mq = 0; mpre = 0;
      end else if (syn_clr) begin
         mq = 0; mpre = 0;
      end else if (load) begin
         mq = int'(d); mpre = 0;
      end else begin
         if (stp) begin
            if (up) mq = (mq < int'(limit)) ? mq + 1 : (sat ? int'(limit) : 0);
            else    mq = (mq > 0) ? mq - 1 : (sat ? 0 : int'(limit));
         end
         if (en) mpre = (mpre + 1) % PRE_DIV;
      end
   endfunction

   task automatic advance();
      @(posedge clk);
      m_clock();
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0;
      up = 1'b1; sat = 1'b0; d = 4'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      advance();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1; load = 1'b1; d = N'($urandom_range(1, 15)); en = 1'b1;
      syn_clr = 1'($urandom_range(0, 1)); limit = 4'd9;
      advance();
      advance();
      idle_inputs();
      @(negedge clk);
      chk_cnt++; if (q !== 4'd0) $display("FAIL reset_q: got %0d want 0", q); else pass_cnt++;
      chk_cnt++; if (min_tick !== 1'b1) $display("FAIL reset_min: got %0b want 1", min_tick); else pass_cnt++;
      chk_cnt++; if (max_tick !== 1'b0) $display("FAIL reset_max: got %0b want 0", max_tick); else pass_cnt++;
      chk_cnt++; if (wrap_tick !== 1'b0) $display("FAIL reset_wrap: got %0b want 0", wrap_tick); else pass_cnt++;
      limit = 4'd0;
      #1;
      chk_cnt++; if (max_tick !== 1'b1) $display("FAIL reset_max_lim0: got %0b want 1", max_tick); else pass_cnt++;
      advance();
   endtask

   task automatic test_wrap_up();
      do_reset();
      limit = 4'd9; sat = 1'b0; up = 1'b1; en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk_cnt++; if (q !== N'(mq)) $display("FAIL up_q[%0d]: got %0d want %0d", i, q, mq); else pass_cnt++;
         chk_cnt++; if (wrap_tick !== m_wrap()) $display("FAIL up_wrap[%0d]: got %0b want %0b", i, wrap_tick, m_wrap()); else pass_cnt++;
`ifndef UNIV_COUNTER_PRESCALE_EN
         chk_cnt++; if (q !== N'(i % 10)) $display("FAIL up_seq[%0d]: got %0d want %0d", i, q, i % 10); else pass_cnt++;
         chk_cnt++; if (wrap_tick !== (i == 9)) $display("FAIL up_wrap_lit[%0d]: got %0b want %0b", i, wrap_tick, i == 9); else pass_cnt++;
`endif
         advance();
      end
   endtask

   task automatic test_wrap_down();
      idle_inputs();
      syn_clr = 1'b1; limit = 4'd9;
      advance();
      syn_clr = 1'b0; up = 1'b0; en = 1'b1; sat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_cnt++; if (q !== N'(mq)) $display("FAIL down_q[%0d]: got %0d want %0d", i, q, mq); else pass_cnt++;
         chk_cnt++; if (wrap_tick !== m_wrap()) $display("FAIL down_wrap[%0d]: got %0b want %0b", i, wrap_tick, m_wrap()); else pass_cnt++;
`ifndef UNIV_COUNTER_PRESCALE_EN
         chk_cnt++; if (q !== N'((i == 0) ? 0 : 10 - i)) $display("FAIL down_seq[%0d]: got %0d want %0d", i, q, (i == 0) ? 0 : 10 - i); else pass_cnt++;
         chk_cnt++; if (wrap_tick !== (i == 0)) $display("FAIL down_wrap_lit[%0d]: got %0b want %0b", i, wrap_tick, i == 0); else pass_cnt++;
`endif
         advance();
      end
   endtask

   task automatic test_saturate();
      idle_inputs();
      syn_clr = 1'b1; limit = 4'd5;
      advance();
      syn_clr = 1'b0; sat = 1'b1; en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         up = (i < 8);
         @(negedge clk);
         chk_cnt++; if (q !== N'(mq)) $display("FAIL sat_q[%0d]: got %0d want %0d", i, q, mq); else pass_cnt++;
         chk_cnt++; if (max_tick !== (mq == 5)) $display("FAIL sat_max[%0d]: got %0b want %0b", i, max_tick, mq == 5); else pass_cnt++;
         chk_cnt++; if (wrap_tick !== 1'b0) $display("FAIL sat_wrap[%0d]: got %0b want 0", i, wrap_tick); else pass_cnt++;
         advance();
`ifndef UNIV_COUNTER_PRESCALE_EN
         if (i == 7) begin
            chk_cnt++; if (q !== 4'd5 || max_tick !== 1'b1) $display("FAIL sat_top: got q=%0d max=%0b want q=5 max=1", q, max_tick); else pass_cnt++;
         end
`endif
      end
`ifndef UNIV_COUNTER_PRESCALE_EN
      chk_cnt++; if (q !== 4'd0) $display("FAIL sat_bottom: got %0d want 0", q); else pass_cnt++;
`endif
   endtask

   task automatic test_load();
      idle_inputs();
      limit = 4'd9; en = 1'b1; up = 1'b1; sat = 1'b0;
      load = 1'b1; d = 4'd12;
      @(negedge clk);
      chk_cnt++; if (wrap_tick !== 1'b0) $display("FAIL load_wrap_mask: got %0b want 0", wrap_tick); else pass_cnt++;
      advance();
      load = 1'b0;
      @(negedge clk);
      chk_cnt++; if (q !== 4'd12) $display("FAIL load_q: got %0d want 12", q); else pass_cnt++;
      chk_cnt++; if (wrap_tick !== m_wrap()) $display("FAIL load_step_wrap: got %0b want %0b", wrap_tick, m_wrap()); else pass_cnt++;
      advance();
      chk_cnt++; if (q !== N'(mq)) $display("FAIL load_step_q: got %0d want %0d", q, mq); else pass_cnt++;
`ifndef UNIV_COUNTER_PRESCALE_EN
      chk_cnt++; if (q !== 4'd0) $display("FAIL load_step_lit: got %0d want 0", q); else pass_cnt++;
`endif
      load = 1'b1; syn_clr = 1'b1; d = 4'd7;
      @(negedge clk);
      chk_cnt++; if (wrap_tick !== 1'b0) $display("FAIL clr_load_wrap: got %0b want 0", wrap_tick); else pass_cnt++;
      advance();
      chk_cnt++; if (q !== 4'd0) $display("FAIL clr_load_q: got %0d want 0", q); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      limit = 4'd9; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 5; i++) advance();
      reset = 1'b1; load = 1'b1; d = 4'd7;
      advance();
      idle_inputs();
      @(negedge clk);
      chk_cnt++; if (q !== 4'd0) $display("FAIL reset_mid_q: got %0d want 0", q); else pass_cnt++;
      chk_cnt++; if (min_tick !== 1'b1) $display("FAIL reset_mid_min: got %0b want 1", min_tick); else pass_cnt++;
      advance();
   endtask

   task automatic test_prescale();
      do_reset();
      limit = 4'd9; en = 1'b1; up = 1'b1; sat = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk_cnt++; if (q !== N'(mq)) $display("FAIL pre_q[%0d]: got %0d want %0d", i, q, mq); else pass_cnt++;
         advance();
      end
`ifdef UNIV_COUNTER_PRESCALE_EN
      chk_cnt++; if (q !== 4'd4) $display("FAIL pre_final: got %0d want 4", q); else pass_cnt++;
`else
      chk_cnt++; if (q !== 4'd6) $display("FAIL pre_final: got %0d want 6", q); else pass_cnt++;
`endif
   endtask

   task automatic test_random();
      do_reset();
      limit = N'($urandom_range(0, 15));
      for (int i = 0; i < 600; i++) begin
         reset   = ($urandom_range(0, 59) == 0);
         syn_clr = ($urandom_range(0, 24) == 0);
         load    = ($urandom_range(0, 11) == 0);
         en      = ($urandom_range(0, 3) != 0);
         up      = 1'($urandom_range(0, 1));
         sat     = 1'($urandom_range(0, 1));
         d       = N'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) limit = N'($urandom_range(0, 15));
         @(negedge clk);
         chk_cnt++; if (q !== N'(mq)) $display("FAIL rnd_q[%0d]: got %0d want %0d", i, q, mq); else pass_cnt++;
         chk_cnt++; if (max_tick !== (mq == int'(limit))) $display("FAIL rnd_max[%0d]: got %0b want %0b", i, max_tick, mq == int'(limit)); else pass_cnt++;
         chk_cnt++; if (min_tick !== (mq == 0)) $display("FAIL rnd_min[%0d]: got %0b want %0b", i, min_tick, mq == 0); else pass_cnt++;
         chk_cnt++; if (wrap_tick !== m_wrap()) $display("FAIL rnd_wrap[%0d]: got %0b want %0b", i, wrap_tick, m_wrap()); else pass_cnt++;
         advance();
      end
   endtask

   initial begin
      idle_inputs();
      limit = 4'd9;
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_load();
      test_reset_mid();
      test_prescale();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
